// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bus: instruction decode fields in, stall/issue/status out.
// The pipeline control side uses master; the scoreboard uses slave.
interface hazard_scoreboard_if #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned LW       = 4,
  parameter int unsigned STALL_CW = 32
);
  logic                id_valid;
  logic [AW-1:0]       id_rs;
  logic [AW-1:0]       id_rt;
  logic                id_rs_used;
  logic                id_rt_used;
  logic                id_wr_en;
  logic [AW-1:0]       id_rd;
  logic [LW-1:0]       id_lat;
  logic                id_div;
  logic                kill_last;
  logic                stall;
  logic                issue;
  logic [NREG-1:0]     pending;
  logic                div_busy;
  logic [STALL_CW-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_en, id_rd, id_lat, id_div,
           kill_last,
    input  stall, issue, pending, div_busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_en, id_rd, id_lat, id_div,
           kill_last,
    output stall, issue, pending, div_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: per-register countdown to bypass availability, divider occupancy,
// and a one-deep undo record so a squashed issue can be rolled back.
module hazard_scoreboard #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned LW       = 4,
  parameter int unsigned DIV_LAT  = 12,
  parameter int unsigned STALL_CW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus_io
);

  localparam logic [LW-1:0] DivLat = LW'(DIV_LAT);
  localparam logic [LW-1:0] One    = LW'(1);

  logic [LW-1:0]       cnt_q [1:NREG-1];
  logic [LW-1:0]       cnt_d [1:NREG-1];
  logic [LW-1:0]       div_cnt_q, div_cnt_d;
  logic                last_v_q, last_v_d;
  logic                last_div_q, last_div_d;
  logic [AW-1:0]       last_rd_q, last_rd_d;
  logic [LW-1:0]       last_old_q, last_old_d;
  logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;

  logic [LW-1:0]   eff_lat, cnt_rs, cnt_rt, cnt_rd;
  logic            raw, waw, structural, live, stall, issue, do_load;
  logic [NREG-1:0] pend;

  function automatic logic [LW-1:0] sat_dec(input logic [LW-1:0] v);
    return (v != '0) ? v - One : '0;
  endfunction

  // Register 0 has no entry, so its lookup reads as zero and never stalls.
  always_comb begin
    cnt_rs = '0;
    cnt_rt = '0;
    cnt_rd = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (bus_io.id_rs == AW'(r)) cnt_rs = cnt_q[r];
      if (bus_io.id_rt == AW'(r)) cnt_rt = cnt_q[r];
      if (bus_io.id_rd == AW'(r)) cnt_rd = cnt_q[r];
    end
  end

  always_comb begin
    eff_lat    = bus_io.id_div ? DivLat : bus_io.id_lat;
    raw        = (bus_io.id_rs_used && (bus_io.id_rs != '0) && (cnt_rs > One)) ||
                 (bus_io.id_rt_used && (bus_io.id_rt != '0) && (cnt_rt > One));
    waw        = bus_io.id_wr_en && (bus_io.id_rd != '0) && (cnt_rd > eff_lat);
    structural = bus_io.id_div && (div_cnt_q != '0);
    live       = bus_io.id_valid && !bus_io.kill_last;
    stall      = live && (raw || waw || structural);
    issue      = live && !stall;
    do_load    = issue && bus_io.id_wr_en && (bus_io.id_rd != '0) && (eff_lat != '0);
  end

  always_comb begin
    for (int unsigned r = 1; r < NREG; r++) cnt_d[r] = sat_dec(cnt_q[r]);
    div_cnt_d  = sat_dec(div_cnt_q);
    last_v_d   = do_load;
    last_div_d = issue && bus_io.id_div;
    last_rd_d  = last_rd_q;
    last_old_d = last_old_q;
    if (do_load) begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (bus_io.id_rd == AW'(r)) cnt_d[r] = eff_lat;
      end
      last_rd_d  = bus_io.id_rd;
      last_old_d = sat_dec(cnt_rd);
    end
    if (issue && bus_io.id_div) div_cnt_d = DivLat;
    // kill_last forces issue low, so the undo never collides with a fresh load.
    if (bus_io.kill_last) begin
      if (last_v_q) begin
        for (int unsigned r = 1; r < NREG; r++) begin
          if (last_rd_q == AW'(r)) cnt_d[r] = sat_dec(last_old_q);
        end
      end
      if (last_div_q) div_cnt_d = '0;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 1; r < NREG; r++) cnt_q[r] <= '0;
      div_cnt_q   <= '0;
      last_v_q    <= 1'b0;
      last_div_q  <= 1'b0;
      last_rd_q   <= '0;
      last_old_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      div_cnt_q   <= div_cnt_d;
      last_v_q    <= last_v_d;
      last_div_q  <= last_div_d;
      last_rd_q   <= last_rd_d;
      last_old_q  <= last_old_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    pend = '0;
    for (int unsigned r = 1; r < NREG; r++) pend[r] = (cnt_q[r] != '0);
  end

  assign bus_io.stall        = stall;
  assign bus_io.issue        = issue;
  assign bus_io.pending      = pend;
  assign bus_io.div_busy     = (div_cnt_q != '0);
  assign bus_io.stall_cycles = stall_cnt_q;

endmodule
